u110_ata_sched: RTL

Arbiter and timing scheduler for the U110 ATA PIO timing engine. It shares the single timing engine between the primary and secondary ATA channels with round-robin arbitration. It holds a CPU-programmable PIO mode per channel and loads the engine with that mode's T1/T2/T0 cycle counts at grant. A watchdog aborts any engine cycle that never completes.

---
 rtl/u110_ata_pkg.sv | 33 +++
 rtl/u110_ata_wdog.sv | 40 ++++
 rtl/u110_ata_sched.sv | 138 +++++++++++++
 3 files changed

// File: rtl/u110_ata_pkg.sv
// Shared types, timing table and helpers for the U110 ATA PIO scheduler.
package u110_ata_pkg;

    // Width of each cumulative timing field sent to the engine.
    localparam int unsigned TW = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StGap
    } state_e;

    typedef struct packed {
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        logic [TW-1:0] t0;
    } timing_t;

    // Cumulative T1/T2/T0 clock counts, indexed by PIO mode 0..4.
    localparam timing_t MODE_TBL [5] = '{
        '{8'd2, 8'd9, 8'd24},
        '{8'd2, 8'd7, 8'd15},
        '{8'd1, 8'd5, 8'd9},
        '{8'd1, 8'd4, 8'd7},
        '{8'd1, 8'd4, 8'd5}
    };

    // Unsupported modes fall back to the slowest, always-safe mode.
    function automatic logic [2:0] mode_clamp(input logic [2:0] mode);
        return (mode > 3'd4) ? 3'd0 : mode;
    endfunction

endpackage

// File: rtl/u110_ata_wdog.sv
// Loadable saturating 8-bit counter with clear/enable and a terminal flag.
module u110_ata_wdog
    import u110_ata_pkg::*;
(
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [TW-1:0] load_val_i,
    input  logic          en_i,
    input  logic [TW-1:0] max_i,
    output logic          term_o
);

    logic [TW-1:0] cnt_q, cnt_d;

    // Next count: load beats clear beats increment; holds at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign term_o = (cnt_q == max_i);

endmodule

// File: rtl/u110_ata_sched.sv
// Round-robin arbiter sharing one PIO timing engine between two ATA channels.
module u110_ata_sched
    import u110_ata_pkg::*;
#(
    parameter logic [7:0] WDOG_MAX = 8'd255,
    parameter logic [1:0] GAP_CLKS = 2'd1
) (
    input  logic          CLK40,
    input  logic          RESETn,
    input  logic          REQ_PRI,
    input  logic          REQ_SEC,
    input  logic          CFG_WE,
    input  logic          CFG_SEL,
    input  logic [2:0]    CFG_MODE,
    input  logic          ENG_DONE,
    output logic          GNT_PRI,
    output logic          GNT_SEC,
    output logic          ENG_START,
    output logic [TW-1:0] ENG_T1,
    output logic [TW-1:0] ENG_T2,
    output logic [TW-1:0] ENG_T0,
    output logic          WDOG_ERR,
    output logic [2:0]    MODE_PRI,
    output logic [2:0]    MODE_SEC
);

    state_e     state_q, state_d;
    logic       last_q, last_d;    // 1 = secondary was granted last / owns the engine in RUN
    logic       start_q, start_d;
    logic       err_q, err_d;
    timing_t    tim_q, tim_d;
    logic [1:0] gap_q, gap_d;
    logic [2:0] mode_pri_q, mode_sec_q;
    logic       win_sec;
    logic       wd_load, wd_en, wd_term;

    // Secondary wins if it is the only requester, or on a tie when primary went last.
    assign win_sec = REQ_SEC && (!REQ_PRI || !last_q);

    // Next-state, grant bookkeeping and timing load.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        tim_d   = tim_q;
        gap_d   = gap_q;
        wd_load = 1'b0;
        wd_en   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (REQ_PRI || REQ_SEC) begin
                    state_d = StRun;
                    last_d  = win_sec;
                    start_d = 1'b1;
                    tim_d   = MODE_TBL[win_sec ? mode_sec_q : mode_pri_q];
                    wd_load = 1'b1;
                end
            end
            StRun: begin
                wd_en = 1'b1;
                if (ENG_DONE) begin
                    state_d = StGap;
                    gap_d   = 2'd0;
                end else if (wd_term) begin
                    state_d = StGap;
                    gap_d   = 2'd0;
                    err_d   = 1'b1;
                end
            end
            StGap: begin
                if (gap_q >= GAP_CLKS - 2'd1) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= StIdle;
            last_q  <= 1'b1;
            start_q <= 1'b0;
            err_q   <= 1'b0;
            tim_q   <= '0;
            gap_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            start_q <= start_d;
            err_q   <= err_d;
            tim_q   <= tim_d;
            gap_q   <= gap_d;
        end
    end

    // Per-channel PIO mode registers; out-of-range writes become mode 0.
    always_ff @(posedge CLK40 or negedge RESETn) begin
        if (!RESETn) begin
            mode_pri_q <= 3'd0;
            mode_sec_q <= 3'd0;
        end else if (CFG_WE) begin
            if (CFG_SEL) begin
                mode_sec_q <= mode_clamp(CFG_MODE);
            end else begin
                mode_pri_q <= mode_clamp(CFG_MODE);
            end
        end
    end

    // Loaded with 1 at grant: the grant clock is already the first RUN clock.
    u110_ata_wdog u_wdog (
        .clk_i      (CLK40),
        .rst_ni     (RESETn),
        .clr_i      (state_q == StGap),
        .load_i     (wd_load),
        .load_val_i (8'd1),
        .en_i       (wd_en),
        .max_i      (WDOG_MAX),
        .term_o     (wd_term)
    );

    // Grants decode from state and owner, so they can never overlap.
    assign GNT_PRI   = (state_q == StRun) && !last_q;
    assign GNT_SEC   = (state_q == StRun) && last_q;
    assign ENG_START = start_q;
    assign ENG_T1    = tim_q.t1;
    assign ENG_T2    = tim_q.t2;
    assign ENG_T0    = tim_q.t0;
    assign WDOG_ERR  = err_q;
    assign MODE_PRI  = mode_pri_q;
    assign MODE_SEC  = mode_sec_q;

endmodule
